// File: rtl/instr_encoder_loader_pkg.sv
// ----------------------------------------------------------------------------
// instr_pkg
// Shared definitions for the instruction encoder/loader and its benches.
//   - instr_type_e   : tuple type codes R=0, J=1, HALT=2, I=3
//   - OP_* constants : reserved major opcodes
//   - state_e        : loader FSM states
//   - instr_fields_t : one decoded field tuple
//   - encode_instr() : packs a tuple into a 32-bit MIPS word
//   - is_illegal()   : true for an I tuple using a reserved opcode
// ----------------------------------------------------------------------------
package instr_pkg;

    typedef enum logic [1:0] {
        TYPE_R    = 2'd0,
        TYPE_J    = 2'd1,
        TYPE_HALT = 2'd2,
        TYPE_I    = 2'd3
    } instr_type_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        instr_type_e itype;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } instr_fields_t;

    function automatic logic [31:0] encode_instr(input instr_fields_t f);
        logic [31:0] w;
        case (f.itype)
            TYPE_R:    w = {OP_RTYPE, f.rs, f.rt, f.rd, f.sa, f.funct};
            TYPE_J:    w = {OP_J, f.target};
            TYPE_HALT: w = {OP_HALT, 26'b0};
            default:   w = {f.opcode, f.rs, f.rt, f.imm};
        endcase
        return w;
    endfunction

    // An I tuple must not collide with the R, J or HALT major opcodes.
    function automatic logic is_illegal(input instr_fields_t f);
        return (f.itype == TYPE_I) &&
               ((f.opcode == OP_RTYPE) || (f.opcode == OP_J) || (f.opcode == OP_HALT));
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// ----------------------------------------------------------------------------
// Bus interfaces of the instruction encoder/loader.
//   enc_in_if : field-tuple handshake (master = tuple source, slave = loader)
//               in_valid/in_ready plus in_type, in_opcode, in_rs, in_rt,
//               in_rd, in_sa, in_funct, in_imm, in_target
//   mem_wr_if : instruction-memory write port (master = loader, slave = memory)
//               mem_we, mem_addr[ADDR_W], mem_wdata[32], mem_ready
// ----------------------------------------------------------------------------
interface enc_in_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_type;
    logic [5:0]  in_opcode;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_sa;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    modport master (
        output in_valid, in_type, in_opcode, in_rs, in_rt, in_rd, in_sa,
               in_funct, in_imm, in_target,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_type, in_opcode, in_rs, in_rt, in_rd, in_sa,
               in_funct, in_imm, in_target,
        output in_ready
    );
endinterface

interface mem_wr_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;

    modport master (
        output mem_we, mem_addr, mem_wdata,
        input  mem_ready
    );

    modport slave (
        input  mem_we, mem_addr, mem_wdata,
        output mem_ready
    );
endinterface

// File: rtl/instr_encoder_loader_enc_fifo.sv
// ----------------------------------------------------------------------------
// enc_fifo
// DEPTH x WIDTH synchronous FIFO holding encoded words awaiting write-out.
//   clk, rst_n  : clock, asynchronous active-low reset (pointers only)
//   push, push_data : write one entry (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   head        : current head entry (undefined content when empty)
//   full, empty : derived from pointers carrying an extra wrap bit
//   count       : current occupancy, 0..DEPTH
// Simultaneous push and pop are both performed.
// ----------------------------------------------------------------------------
module enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en;
    logic             pop_en;

    always_comb begin
        full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        empty = (wr_ptr_q == rd_ptr_q);
        count = wr_ptr_q - rd_ptr_q;
        head  = mem_q[rd_ptr_q[PTR_W-1:0]];

        push_en  = push && !full;
        pop_en   = pop && !empty;
        wr_ptr_d = push_en ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop_en  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only observed while non-empty.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader
// Packs decoded field tuples into 32-bit MIPS words and writes them to
// instruction memory at consecutive addresses via a small FIFO. A session
// starts on `start` (from IDLE or DONE) and ends once the HALT word written.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : begin a session (honoured in IDLE/DONE only)
//   base_addr    : first write address, sampled on accepted start
//   in_bus       : enc_in_if.slave field-tuple handshake
//   mem_bus      : mem_wr_if.master memory write port
//   busy, done   : LOAD/DRAIN, DONE state indications
//   word_count   : words written this session
//   err_illegal  : sticky, illegal I opcode seen
//   err_wrap     : sticky, write address wrapped past the top of memory
//   checksum     : XOR of all written words (only with INSTR_ENC_CHECKSUM_EN)
// Optional feature macro: INSTR_ENC_CHECKSUM_EN
// ----------------------------------------------------------------------------
module instr_encoder_loader
    import instr_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    enc_in_if.slave           in_bus,
    mem_wr_if.master          mem_bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_illegal,
    output logic              err_wrap
`ifdef INSTR_ENC_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic              err_ill_q, err_ill_d;
    logic              err_wrap_q, err_wrap_d;
`ifdef INSTR_ENC_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    instr_fields_t     fields;
    logic              in_ready_c;
    logic              mem_we_c;
    logic [31:0]       mem_wdata_c;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       fifo_head;
    logic [CNT_W-1:0]  fifo_count;

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (encode_instr(fields)),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        fields.itype  = instr_type_e'(in_bus.in_type);
        fields.opcode = in_bus.in_opcode;
        fields.rs     = in_bus.in_rs;
        fields.rt     = in_bus.in_rt;
        fields.rd     = in_bus.in_rd;
        fields.sa     = in_bus.in_sa;
        fields.funct  = in_bus.in_funct;
        fields.imm    = in_bus.in_imm;
        fields.target = in_bus.in_target;

        state_d    = state_q;
        addr_d     = addr_q;
        wcnt_d     = wcnt_q;
        err_ill_d  = err_ill_q;
        err_wrap_d = err_wrap_q;
`ifdef INSTR_ENC_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        in_ready_c = 1'b0;
        accept     = 1'b0;
        push       = 1'b0;

        // Write side runs in LOAD and DRAIN; the FIFO is empty elsewhere.
        mem_we_c    = ((state_q == ST_LOAD) || (state_q == ST_DRAIN)) && !fifo_empty;
        mem_wdata_c = mem_we_c ? fifo_head : '0;
        pop         = mem_we_c && mem_bus.mem_ready;

        if (pop) begin
            addr_d = addr_q + ADDR_W'(1);
            wcnt_d = wcnt_q + (ADDR_W+1)'(1);
            if (addr_q == '1) begin
                err_wrap_d = 1'b1;
            end
`ifdef INSTR_ENC_CHECKSUM_EN
            csum_d = csum_q ^ fifo_head;
`endif
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    addr_d     = base_addr;
                    wcnt_d     = '0;
                    err_ill_d  = 1'b0;
                    err_wrap_d = 1'b0;
`ifdef INSTR_ENC_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            ST_LOAD: begin
                // Ready depends only on registered FIFO state, never on pop.
                in_ready_c = !fifo_full;
                accept     = in_bus.in_valid && in_ready_c;
                if (accept) begin
                    if (is_illegal(fields)) begin
                        err_ill_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                    if (fields.itype == TYPE_HALT) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && (fifo_count == CNT_W'(1))) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wcnt_q     <= '0;
            err_ill_q  <= 1'b0;
            err_wrap_q <= 1'b0;
`ifdef INSTR_ENC_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wcnt_q     <= wcnt_d;
            err_ill_q  <= err_ill_d;
            err_wrap_q <= err_wrap_d;
`ifdef INSTR_ENC_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign in_bus.in_ready   = in_ready_c;
    assign mem_bus.mem_we    = mem_we_c;
    assign mem_bus.mem_addr  = addr_q;
    assign mem_bus.mem_wdata = mem_wdata_c;

    assign busy        = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign word_count  = wcnt_q;
    assign err_illegal = err_ill_q;
    assign err_wrap    = err_wrap_q;
`ifdef INSTR_ENC_CHECKSUM_EN
    assign checksum    = csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// Self-checking bench for instr_encoder_loader (ADDR_W=8, DEPTH=4).
// A reference model computes expected words with plain arithmetic; a monitor
// records every completed memory write for comparison after each session.
// ----------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int unsigned P26 = 32'h0400_0000;
    localparam int unsigned P21 = 32'h0020_0000;
    localparam int unsigned P16 = 32'h0001_0000;
    localparam int unsigned P11 = 32'h0000_0800;
    localparam int unsigned P6  = 32'h0000_0040;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] base_addr = 8'h00;
    logic       busy, done, err_illegal, err_wrap;
    logic [8:0] word_count;
`ifdef INSTR_ENC_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    enc_in_if                 in_if ();
    mem_wr_if #(.ADDR_W(8))   mem_if ();

    instr_encoder_loader #(
        .ADDR_W (8),
        .DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .in_bus      (in_if),
        .mem_bus     (mem_if),
        .busy        (busy),
        .done        (done),
        .word_count  (word_count),
        .err_illegal (err_illegal),
        .err_wrap    (err_wrap)
`ifdef INSTR_ENC_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    // mem_ready: either a fixed level or a random level per cycle
    logic ready_force = 1'b1;
    logic rnd_en = 1'b0;
    logic rnd_bit = 1'b1;
    always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);
    assign mem_if.mem_ready = rnd_en ? rnd_bit : ready_force;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         cap_q[$];
    int unsigned exp_q[$];
    logic [7:0]  sess_base;
    logic        sess_ill;
    int          chks = 0;
    int          errs = 0;

    // A write presented at the negedge completes at the following posedge.
    always @(negedge clk) begin
        if (rst_n && mem_if.mem_we && mem_if.mem_ready)
            cap_q.push_back('{mem_if.mem_addr, mem_if.mem_wdata});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cap_data(input int i);
        if (i < cap_q.size()) return cap_q[i].data;
        return 'x;
    endfunction

    function automatic bit model_illegal(input int t, input int unsigned op);
        return (t == 3) && (op == 0 || op == 2 || op == 63);
    endfunction

    function automatic int unsigned model_word(input int t, input int unsigned op,
        input int unsigned rs, input int unsigned rt, input int unsigned rd,
        input int unsigned sa, input int unsigned fn, input int unsigned imm,
        input int unsigned tgt);
        case (t)
            0:       return rs * P21 + rt * P16 + rd * P11 + sa * P6 + fn;
            1:       return 2 * P26 + tgt;
            2:       return 63 * P26;
            default: return op * P26 + rs * P21 + rt * P16 + imm;
        endcase
    endfunction

    task automatic send(input int t, input int unsigned op, input int unsigned rs,
        input int unsigned rt, input int unsigned rd, input int unsigned sa,
        input int unsigned fn, input int unsigned imm, input int unsigned tgt);
        int cnt;
        cnt = 0;
        in_if.in_valid  = 1'b1;
        in_if.in_type   = t[1:0];
        in_if.in_opcode = op[5:0];
        in_if.in_rs     = rs[4:0];
        in_if.in_rt     = rt[4:0];
        in_if.in_rd     = rd[4:0];
        in_if.in_sa     = sa[4:0];
        in_if.in_funct  = fn[5:0];
        in_if.in_imm    = imm[15:0];
        in_if.in_target = tgt[25:0];
        forever begin
            @(negedge clk);
            if (in_if.in_ready) break;
            cnt++;
            if (cnt >= 1000) break;
        end
        check("accept", in_if.in_ready, 1);
        @(posedge clk); #1;
        in_if.in_valid = 1'b0;
        if (model_illegal(t, op)) sess_ill = 1'b1;
        else exp_q.push_back(model_word(t, op, rs, rt, rd, sa, fn, imm, tgt));
    endtask

    task automatic send_halt();
        send(2, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic send_random(input bit allow_illegal);
        int          t;
        int unsigned op;
        t = $urandom_range(0, 2);
        if (t == 2) t = 3;
        if (t == 3 && allow_illegal && $urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
                0:       op = 0;
                1:       op = 2;
                default: op = 63;
            endcase
        end else begin
            op = $urandom_range(0, 63);
            while (model_illegal(3, op)) op = $urandom_range(0, 63);
        end
        send(t, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
             $urandom_range(0, 32'h3FF_FFFF));
    endtask

    task automatic start_session(input logic [7:0] b);
        cap_q.delete();
        exp_q.delete();
        sess_base = b;
        sess_ill  = 1'b0;
        base_addr = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done();
        int cnt;
        cnt = 0;
        while (!done && cnt < 2000) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("done", done, 1);
    endtask

    task automatic verify(input string tag);
        int unsigned n;
        logic [7:0]  a;
        logic [31:0] csum;
        n    = exp_q.size();
        csum = '0;
        check({tag, "_nwrites"}, cap_q.size(), n);
        for (int i = 0; i < n && i < cap_q.size(); i++) begin
            a = sess_base + 8'(i);
            check({tag, "_addr"}, cap_q[i].addr, a);
            check({tag, "_data"}, cap_q[i].data, exp_q[i]);
            csum = csum ^ exp_q[i];
        end
        check({tag, "_word_count"}, word_count, n);
        check({tag, "_mem_addr"}, mem_if.mem_addr, 8'(sess_base + 8'(n)));
        check({tag, "_err_wrap"}, err_wrap, (int'(sess_base) + n) >= 256);
        check({tag, "_err_illegal"}, err_illegal, sess_ill);
        check({tag, "_busy"}, busy, 0);
`ifdef INSTR_ENC_CHECKSUM_EN
        check({tag, "_checksum"}, checksum, csum);
`endif
    endtask

    initial begin
        logic [31:0] w;

        in_if.in_valid  = 1'b0;
        in_if.in_type   = '0;
        in_if.in_opcode = '0;
        in_if.in_rs     = '0;
        in_if.in_rt     = '0;
        in_if.in_rd     = '0;
        in_if.in_sa     = '0;
        in_if.in_funct  = '0;
        in_if.in_imm    = '0;
        in_if.in_target = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_if.in_ready, 0);
        check("rst_mem_we", mem_if.mem_we, 0);
        check("rst_mem_addr", mem_if.mem_addr, 0);
        check("rst_mem_wdata", mem_if.mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_word_count", word_count, 0);
        check("rst_err_illegal", err_illegal, 0);
        check("rst_err_wrap", err_wrap, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", in_if.in_ready, 0);

        // R add followed by HALT
        ready_force = 1'b1;
        start_session(8'h10);
        check("load_busy", busy, 1);
        send(0, 0, 1, 2, 3, 0, 32'h20, 0, 0);
        send_halt();
        wait_done();
        verify("radd");
        check("radd_word0", cap_data(0), 32'h0022_1820);
        check("radd_word1", cap_data(1), 32'hFC00_0000);
        check("radd_wc", word_count, 2);

        // I/J mix with a decode round-trip
        start_session(8'h20);
        send(3, 32'h23, 4, 5, 0, 0, 0, 32'hFFFC, 0);
        send(1, 0, 0, 0, 0, 0, 0, 0, 32'h40);
        send_halt();
        wait_done();
        verify("ij");
        check("ij_word0", cap_data(0), 32'h8C85_FFFC);
        check("ij_word1", cap_data(1), 32'h0800_0040);
        w = cap_data(0);
        check("ij_dec_op", w[31:26], 32'h23);
        check("ij_dec_rs", w[25:21], 4);
        check("ij_dec_rt", w[20:16], 5);
        check("ij_dec_imm", w[15:0], 32'hFFFC);
        w = cap_data(1);
        check("ij_dec_jop", w[31:26], 2);
        check("ij_dec_tgt", w[25:0], 32'h40);

        // Backpressure: four accepts fill the FIFO
        ready_force = 1'b0;
        start_session(8'h40);
        repeat (4) send(0, 0, $urandom_range(0, 31), $urandom_range(0, 31),
                        $urandom_range(0, 31), $urandom_range(0, 31),
                        $urandom_range(0, 63), 0, 0);
        check("bp_in_ready_full", in_if.in_ready, 0);
        check("bp_mem_we", mem_if.mem_we, 1);
        check("bp_addr", mem_if.mem_addr, 8'h40);
        check("bp_wdata", mem_if.mem_wdata, exp_q[0]);
        repeat (3) @(posedge clk);
        #1;
        check("bp_in_ready_hold", in_if.in_ready, 0);
        check("bp_mem_we_hold", mem_if.mem_we, 1);
        check("bp_addr_hold", mem_if.mem_addr, 8'h40);
        check("bp_wdata_hold", mem_if.mem_wdata, exp_q[0]);
        check("bp_wc_hold", word_count, 0);
        ready_force = 1'b1;
        send(0, 0, 7, 8, 9, 10, 11, 0, 0);
        send_halt();
        wait_done();
        verify("bp");

        // Illegal I opcode between legal tuples
        start_session(8'h80);
        send_random(1'b0);
        send(3, 0, 1, 2, 0, 0, 0, 32'h1234, 0);
        send_random(1'b0);
        send_halt();
        wait_done();
        verify("ill");
        check("ill_flag", err_illegal, 1);
        check("ill_words", cap_q.size(), 3);

        // Address wrap
        start_session(8'hFE);
        check("wrap_ill_cleared", err_illegal, 0);
        repeat (3) send_random(1'b0);
        send_halt();
        wait_done();
        verify("wrap");
        check("wrap_flag", err_wrap, 1);
        check("wrap_wc", word_count, 4);

        // Reset during DRAIN with two entries queued
        ready_force = 1'b0;
        start_session(8'h30);
        check("rd_wrap_cleared", err_wrap, 0);
        send_random(1'b0);
        send_halt();
        check("rd_busy", busy, 1);
        check("rd_mem_we", mem_if.mem_we, 1);
        rst_n = 1'b0;
        #1;
        check("rd_mem_we_rst", mem_if.mem_we, 0);
        check("rd_busy_rst", busy, 0);
        check("rd_done_rst", done, 0);
        check("rd_addr_rst", mem_if.mem_addr, 0);
        check("rd_wc_rst", word_count, 0);
        check("rd_in_ready_rst", in_if.in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready_force = 1'b1;
        @(posedge clk); #1;
        check("rd_no_writes", cap_q.size(), 0);
        start_session(8'h00);
        repeat (3) send_random(1'b0);
        send_halt();
        wait_done();
        verify("clean");

        // Randomized sessions with random memory backpressure
        rnd_en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            start_session(8'($urandom_range(0, 255)));
            for (int k = 0; k < int'($urandom_range(5, 12)); k++) send_random(1'b1);
            send_halt();
            wait_done();
            verify("rand");
        end
        rnd_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", chks, errs);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart of the ID-stage decoder: accepts decoded field tuples (type, opcode, rs, rt, rd, sa, funct, immediate, jump target) and packs them into 32-bit MIPS instruction words.
- Writes the encoded words into instruction memory at consecutive addresses through a small FIFO.
- Used by the bench and boot path to load programs.
- A load session ends when a HALT word has been written.

Parameters:
- ADDR_W, 8: instruction-memory word-address width.
- DEPTH, 4: encode FIFO depth in entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin load session; honoured only in IDLE or DONE
- base_addr  in  ADDR_W  first write address; sampled on accepted start
- in_valid  in  1  field tuple valid
- in_ready  out  1  tuple accepted when in_valid && in_ready
- in_type  in  2  R=0, J=1, HALT=2, I=3
- in_opcode  in  6  opcode; used for I type only
- in_rs, in_rt, in_rd, in_sa  in  5 each  register and shift fields
- in_funct  in  6  function field
- in_imm  in  16  immediate or address offset
- in_target  in  26  jump target
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  encoded word
- mem_ready  in  1  write completes on mem_we && mem_ready
- busy  out  1  high in LOAD or DRAIN
- done  out  1  high in DONE
- word_count  out  ADDR_W+1  words written this session
- err_illegal  out  1  sticky; illegal I opcode seen
- err_wrap  out  1  sticky; address wrapped past the top of memory

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the FIFO is empty.
- Encoding:
  - R: {6'b000000, rs, rt, rd, sa, funct}.
  - J: {6'b000010, target}.
  - HALT: {6'b111111, 26'b0}.
  - I: {opcode, rs, rt, imm}.
  - Unused input fields are ignored.
- Illegal input: I type with opcode 000000, 000010 or 111111.
  - The tuple is accepted (consumed) but not pushed.
  - err_illegal is set.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: in_ready=0, mem_we=0. start moves to LOAD, mem_addr=base_addr, word_count=0, both error flags cleared.
  - LOAD: in_ready = !fifo_full (combinational on registered full only; no pass-through when full). A legal accepted tuple is encoded and pushed at the clock edge. Accepting HALT pushes the HALT word and moves to DRAIN.
  - DRAIN: in_ready=0. Moves to DONE on the cycle the last FIFO entry's write completes.
  - DONE: done=1, holding mem_addr and word_count. start re-enters LOAD as from IDLE.
  - start is ignored in LOAD and DRAIN.
- Write side, active in LOAD and DRAIN:
  - mem_we = !fifo_empty.
  - mem_wdata = FIFO head; mem_addr is registered.
  - Completion (mem_we && mem_ready) pops the head, increments mem_addr modulo 2^ADDR_W and increments word_count.
  - mem_we, mem_addr and mem_wdata stay stable while mem_ready=0.
- Latency: a tuple accepted at edge N is on mem_wdata with mem_we=1 from cycle N+1 at the earliest.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.
- Wrap: if mem_addr wraps from all-ones to 0, err_wrap is set and writing continues.
- Reset asserted mid-session: immediate return to IDLE, FIFO flushed, no further writes.

Optional Feature:
- Macro INSTR_ENC_CHECKSUM_EN.
- Defined:
  - Extra output checksum[31:0].
  - Cleared on accepted start and on reset.
  - Updated as checksum ^= mem_wdata on every completed write, HALT included.
  - Valid once done=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package instr_pkg:
  - instruction-type encodings R/J/HALT/I;
  - opcode constants OP_RTYPE=6'b000000, OP_J=6'b000010, OP_HALT=6'b111111;
  - FSM state typedef;
  - pure function encode_instr returning 32 bits, shared with the decoder bench.
- One sub-module, enc_fifo:
  - parameterised DEPTH x 32;
  - full/empty from pointers carrying an extra wrap bit;
  - simultaneous push/pop supported.

Test Plan:
- R add: start with base 8'h10, push R rs=1 rt=2 rd=3 sa=0 funct=6'h20, then HALT, mem_ready=1 → writes 32'h00221820 at 8'h10 and 32'hFC000000 at 8'h11; done=1; word_count=2.
- I/J mix: I opcode 6'h23 rs=4 rt=5 imm=16'hFFFC → 32'h8C85FFFC; J target 26'h0000040 → 32'h08000040; then HALT. Three consecutive addresses; a decoder round-trip reproduces the fields.
- Backpressure: mem_ready=0 while pushing 5 R tuples with DEPTH=4 → in_ready drops after the 4th accept. mem_* stay stable. Releasing mem_ready drains the entries in order and addresses increment by 1.
- Illegal: I tuple with opcode 6'h00 between two legal tuples, then HALT → err_illegal=1; only 3 words written; no address gap.
- Wrap: base_addr 8'hFE, 3 tuples plus HALT → addresses FE, FF, 00, 01; err_wrap=1; word_count=4.
- Reset mid-DRAIN: assert rst_n=0 with 2 entries queued → mem_we=0 immediately; IDLE; outputs 0. A subsequent start performs a clean session.
